// File: rtl/fdiv_sequencer.sv
// fdiv_sequencer: issue/collection stage in front of the sequential
// single-precision float divider. Special operands and exponent range
// faults are answered locally; every other pair is handed to the divider
// and its result is collected, with a watchdog against a silent divider.
// Optional statistics counters are compiled in with FDIV_SEQ_STATS_EN.
module fdiv_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 63
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic        div_start,
    output logic [31:0] div_a,
    output logic [31:0] div_b,
    input  logic [31:0] div_result,
    input  logic        div_done,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [4:0]  out_flags
`ifdef FDIV_SEQ_STATS_EN
    ,
    output logic [15:0] stat_ops,
    output logic [15:0] stat_bypass,
    output logic [15:0] stat_timeout
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        CLASSIFY,
        ISSUE,
        WAIT,
        OUTPUT
    } state_t;

    localparam logic [31:0] QNAN     = 32'h7FC0_0000;
    localparam logic [8:0]  WD_LIMIT = 9'(TIMEOUT_CYCLES);

    state_t      state;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [7:0]  wd_cnt;
    logic [8:0]  wd_next;

    // Operand fields of the captured pair; denormals count as zero
    logic        sign_q;
    logic [7:0]  a_exp;
    logic [7:0]  b_exp;
    logic        a_nan;
    logic        b_nan;
    logic        a_inf;
    logic        b_inf;
    logic        a_zero;
    logic        b_zero;
    logic        m_lt;
    logic signed [9:0] e_calc;

    logic        cls_issue;
    logic [31:0] cls_result;
    logic [4:0]  cls_flags;

    assign sign_q  = a_q[31] ^ b_q[31];
    assign a_exp   = a_q[30:23];
    assign b_exp   = b_q[30:23];
    assign a_nan   = (a_exp == 8'hFF) && (a_q[22:0] != 23'd0);
    assign b_nan   = (b_exp == 8'hFF) && (b_q[22:0] != 23'd0);
    assign a_inf   = (a_exp == 8'hFF) && (a_q[22:0] == 23'd0);
    assign b_inf   = (b_exp == 8'hFF) && (b_q[22:0] == 23'd0);
    assign a_zero  = (a_exp == 8'h00);
    assign b_zero  = (b_exp == 8'h00);
    assign m_lt    = ({1'b1, a_q[22:0]} < {1'b1, b_q[22:0]});
    assign e_calc  = $signed({2'b00, a_exp}) - $signed({2'b00, b_exp})
                   + 10'sd127 - $signed({9'd0, m_lt});
    assign wd_next = {1'b0, wd_cnt} + 9'd1;

    // Only IDLE accepts a pair; reset forces ready low combinationally
    assign in_ready = (state == IDLE) && !rst;

    // Classify the captured pair: local answer, or hand it to the divider
    always_comb begin
        cls_issue  = 1'b0;
        cls_result = 32'h0000_0000;
        cls_flags  = 5'b00000;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            cls_result = QNAN;
            cls_flags  = 5'b10000;
        end else if (b_zero && !a_zero && !a_inf) begin
            cls_result = {sign_q, 8'hFF, 23'd0};
            cls_flags  = 5'b01000;
        end else if (a_inf) begin
            cls_result = {sign_q, 8'hFF, 23'd0};
        end else if (a_zero || b_inf) begin
            cls_result = {sign_q, 31'd0};
        end else if (e_calc > 10'sd254) begin
            cls_result = {sign_q, 8'hFF, 23'd0};
            cls_flags  = 5'b00100;
        end else if (e_calc < 10'sd1) begin
            cls_result = {sign_q, 31'd0};
            cls_flags  = 5'b00010;
        end else begin
            cls_issue  = 1'b1;
        end
    end

    // Main sequencer: one operation at a time, all outputs registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            a_q        <= 32'd0;
            b_q        <= 32'd0;
            wd_cnt     <= 8'd0;
            div_start  <= 1'b0;
            div_a      <= 32'd0;
            div_b      <= 32'd0;
            out_valid  <= 1'b0;
            out_result <= 32'd0;
            out_flags  <= 5'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= in_a;
                        b_q   <= in_b;
                        state <= CLASSIFY;
                    end
                end
                CLASSIFY: begin
                    if (cls_issue) begin
                        div_start <= 1'b1;
                        div_a     <= a_q;
                        div_b     <= b_q;
                        state     <= ISSUE;
                    end else begin
                        out_valid  <= 1'b1;
                        out_result <= cls_result;
                        out_flags  <= cls_flags;
                        state      <= OUTPUT;
                    end
                end
                ISSUE: begin
                    div_start <= 1'b0;
                    wd_cnt    <= 8'd0;
                    state     <= WAIT;
                end
                WAIT: begin
                    if (div_done) begin
                        out_valid  <= 1'b1;
                        out_result <= div_result;
                        out_flags  <= 5'b00000;
                        state      <= OUTPUT;
                    end else if (wd_next == WD_LIMIT) begin
                        out_valid  <= 1'b1;
                        out_result <= QNAN;
                        out_flags  <= 5'b00001;
                        state      <= OUTPUT;
                    end else begin
                        wd_cnt <= wd_next[7:0];
                    end
                end
                OUTPUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FDIV_SEQ_STATS_EN
    logic bypass_q;

    // Count completed operations, locally answered ones and timeouts
    always_ff @(posedge clk) begin
        if (rst) begin
            bypass_q     <= 1'b0;
            stat_ops     <= 16'd0;
            stat_bypass  <= 16'd0;
            stat_timeout <= 16'd0;
        end else begin
            if (state == CLASSIFY) begin
                bypass_q <= !cls_issue;
            end
            if (out_valid && out_ready) begin
                stat_ops <= stat_ops + 16'd1;
                if (bypass_q) begin
                    stat_bypass <= stat_bypass + 16'd1;
                end
                if (out_flags[0]) begin
                    stat_timeout <= stat_timeout + 16'd1;
                end
            end
        end
    end
`endif

endmodule
